// File: rtl/array_port_driver_pkg.sv
// rtl/array_port_driver_pkg.sv - shared types for the array port driver
// scam_model_types: integer array typedef (int_5) shared by the generated array modules.
// array_port_driver_types: burst depth default, element array typedef and the FSM state enum.
package scam_model_types;
   typedef logic signed [31:0] int_5 [5];
endpackage

package array_port_driver_types;
   import scam_model_types::*;

   localparam int DEPTH_DEFAULT = 5;

   typedef logic signed [31:0] int_DEPTH [DEPTH_DEFAULT];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RECV = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/array_port_driver.sv
// rtl/array_port_driver.sv - blocking-port peer that sends a DEPTH-element sequence and collects replies
// Optional feature macro: ARRAY_PORT_DRIVER_ECHO_CHECK_EN (reply vs. sent element comparison).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   start, seed                      burst request (IDLE only) and first element value
//   tx, tx_sync, tx_notify           outgoing element handshake
//   rx, rx_sync, rx_notify           incoming reply handshake
//   busy, done, sum, err_count       status: in burst, completion pulse, reply sum, echo mismatches
module array_port_driver
   import array_port_driver_types::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int STEP  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] seed,
   output logic [31:0] tx,
   input  logic        tx_sync,
   output logic        tx_notify,
   input  logic [31:0] rx,
   input  logic        rx_sync,
   output logic        rx_notify,
   output logic        busy,
   output logic        done,
   output logic [31:0] sum,
   output logic [31:0] err_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] index;
   logic [31:0]      tx_array [DEPTH];
   logic [31:0]      rx_array [DEPTH];
   logic [31:0]      sum_q;
   logic             busy_q;
   logic             tx_notify_q;
   logic             rx_notify_q;

   // The element on the wire is always the one recorded at the current index,
   // so tx cannot drift from tx_array and is stable for the whole SEND phase.
   assign tx        = tx_array[index];
   assign tx_notify = tx_notify_q;
   assign rx_notify = rx_notify_q;
   assign busy      = busy_q;
   assign done      = (state == DONE);
   assign sum       = sum_q;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start)   state_next = SEND;
         SEND: if (tx_sync) state_next = RECV;
         RECV: if (rx_sync) state_next = (index == LAST_IDX) ? DONE : SEND;
         DONE:              state_next = IDLE;
         default:           state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

`ifdef ARRAY_PORT_DRIVER_ECHO_CHECK_EN
   logic [31:0] err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else if (state == IDLE && start) begin
         err_q <= '0;
      end else if (state == RECV && rx_sync && rx != tx_array[index]) begin
         err_q <= err_q + 32'd1;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index       <= '0;
         sum_q       <= '0;
         busy_q      <= 1'b0;
         tx_notify_q <= 1'b0;
         rx_notify_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tx_array[i] <= '0;
            rx_array[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tx_array[0] <= seed;
                  index       <= '0;
                  sum_q       <= '0;
                  busy_q      <= 1'b1;
                  tx_notify_q <= 1'b1;
               end
            end
            SEND: begin
               if (tx_sync) begin
                  tx_notify_q <= 1'b0;
                  rx_notify_q <= 1'b1;
               end
            end
            RECV: begin
               if (rx_sync) begin
                  rx_array[index] <= rx;
                  sum_q           <= sum_q + rx;
                  rx_notify_q     <= 1'b0;
                  if (index != LAST_IDX) begin
                     index                     <= index + IDX_W'(1);
                     tx_array[index + IDX_W'(1)] <= tx_array[index] + 32'(STEP);
                     tx_notify_q               <= 1'b1;
                  end
               end
            end
            DONE: begin
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_array_port_driver.sv
// tb/tb_array_port_driver.sv - directed vector bench for array_port_driver
module tb_array_port_driver;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] seed;
   logic [31:0] tx;
   logic        tx_sync;
   logic        tx_notify;
   logic [31:0] rx;
   logic        rx_sync;
   logic        rx_notify;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic [31:0] err_count;

   int checks   = 0;
   int failures = 0;

   array_port_driver #(.DEPTH(5), .STEP(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed      (seed),
      .tx        (tx),
      .tx_sync   (tx_sync),
      .tx_notify (tx_notify),
      .rx        (rx),
      .rx_sync   (rx_sync),
      .rx_notify (rx_notify),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .err_count (err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string             name;
      logic [31:0]       seed;
      int                mode;          // reply = tx + mode
      int                stall_elem;    // element whose tx_sync is held low
      int                stall_cycles;
      bit                restart;       // pulse start again while in RECV
      logic [0:4][31:0]  exp_tx;
      logic [31:0]       exp_sum;
      int                exp_done_cyc;
      logic [31:0]       exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_burst(input vec_t v);
      logic [31:0] txs [8];
      int          ntx = 0;
      int          nrx = 0;
      int          ndone = 0;
      int          done_cyc = -1;
      int          stall_left = v.stall_cycles;
      bit          restarted = 0;
      bit          both_bad = 0;
      bit          stall_bad = 0;
      logic [31:0] stall_val = '0;
      for (int i = 0; i < 8; i++) txs[i] = '0;

      @(negedge clk);
      seed    = v.seed;
      start   = 1'b1;
      tx_sync = 1'b1;
      rx_sync = 1'b1;
      for (int cyc = 1; cyc <= 100 && ndone == 0; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (tx_notify && rx_notify) both_bad = 1;
         if (v.restart && !restarted && rx_notify) begin
            start     = 1'b1;
            restarted = 1;
         end
         tx_sync = 1'b1;
         if (tx_notify && ntx == v.stall_elem && stall_left > 0) begin
            if (stall_left == v.stall_cycles) stall_val = tx;
            else if (tx !== stall_val) stall_bad = 1;
            tx_sync = 1'b0;
            stall_left--;
         end
         rx = tx + 32'(v.mode);
         if (tx_notify && tx_sync) begin
            if (ntx < 8) txs[ntx] = tx;
            ntx++;
         end
         if (rx_notify && rx_sync) nrx++;
      end
      @(negedge clk);
      if (done) ndone++;
      check({v.name, " busy_after"}, 32'(busy), 32'd0);
      check({v.name, " tx_count"}, 32'(ntx), 32'd5);
      check({v.name, " rx_count"}, 32'(nrx), 32'd5);
      for (int i = 0; i < 5; i++)
         check($sformatf("%s tx[%0d]", v.name, i), txs[i], v.exp_tx[i]);
      check({v.name, " sum"}, sum, v.exp_sum);
      check({v.name, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done_cyc));
      check({v.name, " done_count"}, 32'(ndone), 32'd1);
      check({v.name, " err_count"}, err_count, v.exp_err);
      check({v.name, " notify_exclusive"}, 32'(both_bad), 32'd0);
      check({v.name, " stall_tx_stable"}, 32'(stall_bad), 32'd0);
      check({v.name, " stall_completed"}, 32'(stall_left), 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      logic [31:0] plus1_err;
`ifdef ARRAY_PORT_DRIVER_ECHO_CHECK_EN
      plus1_err = 32'd5;
`else
      plus1_err = 32'd0;
`endif
      vecs[0] = '{"echo_seed10", 32'd10, 0, -1, 0, 1'b0,
                  {32'd10, 32'd11, 32'd12, 32'd13, 32'd14}, 32'd60, 11, 32'd0};
      vecs[1] = '{"stall_elem2", 32'd10, 0, 2, 3, 1'b0,
                  {32'd10, 32'd11, 32'd12, 32'd13, 32'd14}, 32'd60, 14, 32'd0};
      vecs[2] = '{"restart_in_recv", 32'd10, 0, -1, 0, 1'b1,
                  {32'd10, 32'd11, 32'd12, 32'd13, 32'd14}, 32'd60, 11, 32'd0};
      vecs[3] = '{"wrap", 32'h7FFFFFFE, 0, -1, 0, 1'b0,
                  {32'h7FFFFFFE, 32'h7FFFFFFF, 32'h80000000, 32'h80000001, 32'h80000002},
                  32'h80000000, 11, 32'd0};
      vecs[4] = '{"reply_plus1", 32'd10, 1, -1, 0, 1'b0,
                  {32'd10, 32'd11, 32'd12, 32'd13, 32'd14}, 32'd65, 11, plus1_err};
      vecs[5] = '{"negative_seed", 32'hFFFFFFFD, 0, -1, 0, 1'b0,
                  {32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1},
                  32'hFFFFFFFB, 11, 32'd0};

      rst = 1'b1; start = 1'b0; seed = '0; tx_sync = 1'b0; rx_sync = 1'b0; rx = '0;
      @(negedge clk);
      check("reset tx", tx, 32'd0);
      check("reset tx_notify", 32'(tx_notify), 32'd0);
      check("reset rx_notify", 32'(rx_notify), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset sum", sum, 32'd0);
      check("reset err_count", err_count, 32'd0);
      rst = 1'b0;

      // sync asserted while no notify is pending must not start anything
      tx_sync = 1'b1; rx_sync = 1'b1;
      repeat (2) @(negedge clk);
      check("idle sync ignored busy", 32'(busy), 32'd0);
      check("idle sync ignored tx_notify", 32'(tx_notify), 32'd0);

      for (int i = 0; i < 6; i++) run_burst(vecs[i]);

      // Reset during the SEND phase of element 3 (cycle 7 after start)
      @(negedge clk);
      seed = 32'd100; start = 1'b1; tx_sync = 1'b1; rx_sync = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         rx = tx;
      end
      check("midrst pre tx", tx, 32'd103);
      check("midrst pre tx_notify", 32'(tx_notify), 32'd1);
      check("midrst pre sum", sum, 32'd303);
      rst = 1'b1;
      #1;
      check("midrst tx_notify", 32'(tx_notify), 32'd0);
      check("midrst rx_notify", 32'(rx_notify), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst sum", sum, 32'd0);
      check("midrst tx", tx, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         vec_t r;
         r = '{"after_reset", 32'd20, 0, -1, 0, 1'b0,
               {32'd20, 32'd21, 32'd22, 32'd23, 32'd24}, 32'd110, 11, 32'd0};
         run_burst(r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
